// File: rtl/alsu_arbiter.sv
// alsu_arbiter: two-requester round-robin arbiter and sequencer for the shared ALSU.
// A granted command is driven onto the ALSU for len+1 cycles. The ALSU pipeline
// (two register stages) is then drained and the ALSU result is returned to the
// requester that owns the grant.
//
// Handshake semantics (request and response side alike): a transfer happens on a
// rising edge where valid and ready are both high. A requester keeps valid and its
// payload stable until that edge. The arbiter keeps rspX_valid and the rsp_* data
// stable until rspX_ready is seen.
module alsu_arbiter #(
    parameter int          LEN_W    = 3,
    parameter logic [15:0] PARK_CMD = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [15:0]      req0_cmd,
    input  logic [LEN_W-1:0] req0_len,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [15:0]      req1_cmd,
    input  logic [LEN_W-1:0] req1_len,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [5:0]       rsp_out,
    output logic [15:0]      rsp_leds,
    output logic             rsp_err,
    output logic [15:0]      alsu_cmd,
    input  logic [5:0]       alsu_out,
    input  logic [15:0]      alsu_leds,
    output logic             busy,
    output logic             grant_id
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT1 = 3'd2,
        WAIT2 = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t           state;
    logic             last_grant;   // requester granted most recently
    logic [15:0]      cmd_q;        // command latched at grant
    logic [LEN_W-1:0] cnt;          // remaining extra issue cycles

    logic             pick1;
    logic             accept;
    logic             in_idle;
    logic [15:0]      sel_cmd;
    logic [LEN_W-1:0] sel_len;
    logic [2:0]       op_q;
    logic             illegal;
    logic             rsp_ready_g;

    // Arbitration, request-side ready, and illegal-command decode.
    always_comb begin
        pick1       = 1'b0;
        in_idle     = (state == IDLE) && rst_n;
        // With both requests pending, the side not served last wins.
        if (req0_valid && req1_valid) begin
            pick1 = ~last_grant;
        end else begin
            pick1 = req1_valid;
        end
        req0_ready  = in_idle && req0_valid && !pick1;
        req1_ready  = in_idle && req1_valid && pick1;
        accept      = req0_ready || req1_ready;
        sel_cmd     = pick1 ? req1_cmd : req0_cmd;
        sel_len     = pick1 ? req1_len : req0_len;
        op_q        = cmd_q[8:6];
        // Opcodes 110/111 are undefined; reductions exist only for OR and XOR.
        illegal     = (op_q == 3'b110) || (op_q == 3'b111) ||
                      ((cmd_q[12] || cmd_q[13]) && (op_q[2:1] != 2'b00));
        rsp_ready_g = grant_id ? rsp1_ready : rsp0_ready;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cmd_q      <= '0;
            cnt        <= '0;
            alsu_cmd   <= PARK_CMD;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_out    <= '0;
            rsp_leds   <= '0;
            rsp_err    <= 1'b0;
            grant_id   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_q      <= sel_cmd;
                        cnt        <= sel_len;
                        grant_id   <= pick1;
                        last_grant <= pick1;
                        alsu_cmd   <= sel_cmd;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        alsu_cmd   <= PARK_CMD;
                    end
                end
                ISSUE: begin
                    // cnt==0 marks the last of the len+1 issue cycles.
                    if (cnt == '0) begin
                        alsu_cmd <= PARK_CMD;
                        state    <= WAIT1;
                    end else begin
                        cnt      <= cnt - LEN_W'(1);
                    end
                end
                WAIT1: begin
                    state <= WAIT2;
                end
                WAIT2: begin
                    // ALSU output now reflects the last issue cycle.
                    rsp_out    <= alsu_out;
                    rsp_leds   <= alsu_leds;
                    rsp_err    <= illegal;
                    rsp0_valid <= ~grant_id;
                    rsp1_valid <= grant_id;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready_g) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    alsu_cmd <= PARK_CMD;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_arbiter.sv
// tb_alsu_arbiter: randomized scoreboard bench for alsu_arbiter with a
// cycle-level ALSU model as the downstream load.
module tb_alsu_arbiter;

    localparam logic [15:0] PARK = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_cmd = '0, req1_cmd = '0;
    logic [2:0]  req0_len = '0, req1_len = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [5:0]  rsp_out;
    logic [15:0] rsp_leds;
    logic        rsp_err;
    logic [15:0] alsu_cmd;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;
    logic        busy, grant_id;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    alsu_arbiter #(.LEN_W(3), .PARK_CMD(PARK)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd), .req0_len(req0_len),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd), .req1_len(req1_len),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_out(rsp_out), .rsp_leds(rsp_leds), .rsp_err(rsp_err),
        .alsu_cmd(alsu_cmd), .alsu_out(alsu_out), .alsu_leds(alsu_leds),
        .busy(busy), .grant_id(grant_id)
    );

    // ---------------- ALSU model (input regs + output regs) ----------------
    function automatic logic [21:0] alsu_step(input logic [15:0] c, input logic [5:0] o,
                                              input logic [15:0] l);
        logic [2:0]  a, b, op;
        logic [5:0]  ae, be, no;
        logic [15:0] nl;
        logic        inv;
        a  = c[2:0];
        b  = c[5:3];
        op = c[8:6];
        ae = {{3{a[2]}}, a};
        be = {{3{b[2]}}, b};
        inv = (op > 3'd5) || ((c[12] || c[13]) && (op > 3'd1));
        no = '0;
        nl = '0;
        if (inv) nl = ~l;
        else if (c[14]) no = {3'b000, a};
        else if (c[15]) no = {3'b000, b};
        else begin
            case (op)
                3'd0: no = c[12] ? {5'b0, |a} : (c[13] ? {5'b0, |b} : {3'b000, a | b});
                3'd1: no = c[12] ? {5'b0, ^a} : (c[13] ? {5'b0, ^b} : {3'b000, a ^ b});
                3'd2: no = ae + be + {5'b0, c[9]};
                3'd3: no = ae * be;
                3'd4: no = c[11] ? {o[4:0], c[10]} : {c[10], o[5:1]};
                3'd5: no = c[11] ? {o[4:0], o[5]} : {o[0], o[5:1]};
                default: no = '0;
            endcase
        end
        return {no, nl};
    endfunction

    logic [15:0] alsu_in_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alsu_in_q <= '0;
            alsu_out  <= '0;
            alsu_leds <= '0;
        end else begin
            alsu_in_q <= alsu_cmd;
            {alsu_out, alsu_leds} <= alsu_step(alsu_in_q, alsu_out, alsu_leds);
        end
    end

    // ---------------- reference model: whole-command result ----------------
    // Result of a command repeated len+1 times starting from a parked (zero) ALSU.
    function automatic logic [22:0] exp_result(input logic [15:0] c, input int len);
        int a, b, sa, sb, op, n, k, v;
        logic err;
        logic [15:0] leds;
        a  = int'(c[2:0]);
        b  = int'(c[5:3]);
        op = int'(c[8:6]);
        n  = len + 1;
        sa = (a >= 4) ? a - 8 : a;
        sb = (b >= 4) ? b - 8 : b;
        err  = (op >= 6) || ((c[12] || c[13]) && op >= 2);
        leds = 16'h0000;
        v    = 0;
        if (err) begin
            if (n % 2 == 1) leds = 16'hFFFF;
        end else if (c[14]) v = a;
        else if (c[15]) v = b;
        else begin
            case (op)
                0: v = c[12] ? ((a != 0) ? 1 : 0) : (c[13] ? ((b != 0) ? 1 : 0) : (a | b));
                1: v = c[12] ? ($countones(c[2:0]) % 2) : (c[13] ? ($countones(c[5:3]) % 2) : (a ^ b));
                2: v = sa + sb + int'(c[9]);
                3: v = sa * sb;
                4: begin
                    k = (n > 6) ? 6 : n;
                    if (c[10]) v = c[11] ? ((1 << k) - 1) : (64 - (1 << (6 - k)));
                end
                default: v = 0;  // rotating an all-zero value stays zero
            endcase
        end
        return {err, leds, 6'(v & 63)};
    endfunction

    // ---------------- scoreboard state ----------------
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [55:0] exp_q[$];        // {id, err, leds[15:0], out[5:0], due[31:0]}
    logic [55:0] cur = '0;
    logic        pending = 1'b0, rsp_active = 1'b0, last_g = 1'b1;
    logic        cur_id = 1'b0;
    logic [15:0] cur_cmd = '0;
    int          cur_len = 0, e0 = 0, due = 0;
    int          wait0 = 0, wait1 = 0;
    logic        m_r0, m_r1;
    logic [15:0] m_cmd;
    logic [22:0] r_tmp;

    // directed expectations supplied by the stimulus process
    logic        dir_on = 1'b0;
    logic [5:0]  dir_out = '0;
    logic [15:0] dir_leds = '0;
    logic        dir_err = 1'b0;
    int          rdy_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_alsu_cmd", alsu_cmd, PARK);
            chk("rst_rsp0_valid", rsp0_valid, 0);
            chk("rst_rsp1_valid", rsp1_valid, 0);
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_rsp_out", rsp_out, 0);
            chk("rst_rsp_leds", rsp_leds, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_grant_id", grant_id, 0);
            exp_q.delete();
            pending    = 1'b0;
            rsp_active = 1'b0;
            last_g     = 1'b1;
            wait0      = 0;
            wait1      = 0;
        end else begin
            // arbitration: nothing accepted while a transaction is outstanding
            if (pending) begin
                m_r0 = 1'b0;
                m_r1 = 1'b0;
            end else if (req0_valid && req1_valid) begin
                m_r0 = last_g;
                m_r1 = ~last_g;
            end else begin
                m_r0 = req0_valid;
                m_r1 = req1_valid;
            end
            chk("req0_ready", req0_ready, m_r0);
            chk("req1_ready", req1_ready, m_r1);
            chk("busy", busy, pending);
            m_cmd = (pending && cyc >= e0 && cyc <= e0 + cur_len) ? cur_cmd : PARK;
            chk("alsu_cmd", alsu_cmd, m_cmd);
            if (pending) chk("grant_id", grant_id, cur_id);

            // response side
            if (rsp0_valid || rsp1_valid) begin
                chk("rsp_onehot", rsp0_valid && rsp1_valid, 0);
                if (!rsp_active) begin
                    if (exp_q.size() == 0) begin
                        flag("rsp_unexpected");
                    end else begin
                        cur = exp_q.pop_front();
                        rsp_active = 1'b1;
                        chk("rsp_id", rsp1_valid, cur[55]);
                        chk("rsp_cycle", cyc, cur[31:0]);
                    end
                end
                if (rsp_active) begin
                    chk("rsp_out", rsp_out, cur[37:32]);
                    chk("rsp_leds", rsp_leds, cur[53:38]);
                    chk("rsp_err", rsp_err, cur[54]);
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        rsp_active = 1'b0;
                        pending    = 1'b0;
                    end
                end
            end else if (rsp_active) begin
                flag("rsp_dropped");
                rsp_active = 1'b0;
                pending    = 1'b0;
            end else if (pending && cyc > due + 1) begin
                flag("rsp_timeout");
                pending = 1'b0;
                exp_q.delete();
            end

            // request handshakes (transfer on the coming edge)
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                cur_id  = req1_valid && req1_ready;
                cur_cmd = cur_id ? req1_cmd : req0_cmd;
                cur_len = int'(cur_id ? req1_len : req0_len);
                e0      = cyc + 1;
                due     = cyc + cur_len + 4;
                pending = 1'b1;
                last_g  = cur_id;
                r_tmp   = dir_on ? {dir_err, dir_leds, dir_out} : exp_result(cur_cmd, cur_len);
                exp_q.push_back({cur_id, r_tmp, 32'(due)});
            end

            // starvation watchdogs
            wait0 = (req0_valid && !req0_ready) ? wait0 + 1 : 0;
            wait1 = (req1_valid && !req1_ready) ? wait1 + 1 : 0;
            if (wait0 > 100) begin flag("req0_starved"); wait0 = 0; end
            if (wait1 > 100) begin flag("req1_starved"); wait1 = 0; end
        end
    end

    // ---------------- response-ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: begin rsp0_ready = 1'b1; rsp1_ready = 1'b1; end
            1: begin
                rsp0_ready = ($urandom_range(0, 3) != 0);
                rsp1_ready = ($urandom_range(0, 3) != 0);
            end
            default: begin rsp0_ready = 1'b1; rsp1_ready = 1'b0; end
        endcase
    end

    // ---------------- request drivers ----------------
    task automatic drive0(input logic [15:0] c, input logic [2:0] l);
        @(posedge clk);
        #1;
        req0_cmd = c;
        req0_len = l;
        req0_valid = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (req0_ready) break;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
    endtask

    task automatic drive1(input logic [15:0] c, input logic [2:0] l);
        @(posedge clk);
        #1;
        req1_cmd = c;
        req1_len = l;
        req1_valid = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (req1_ready) break;
        end
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
    endtask

    function automatic logic [15:0] rand_cmd();
        logic [15:0] c;
        c = 16'($urandom);
        if ($urandom_range(0, 3) != 0) c[13:12] = 2'b00;
        if ($urandom_range(0, 3) != 0) c[15:14] = 2'b00;
        return c;
    endfunction

    task automatic drain();
        for (int i = 0; i < 300 && (pending || exp_q.size() != 0); i++) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // directed commands with hand-computed results
        dir_on = 1'b1;
        dir_out = 6'h06; dir_leds = 16'h0000; dir_err = 1'b0;
        drive0(16'h0293, 3'd0);           // add 3+2+cin
        dir_out = 6'h3A; dir_leds = 16'h0000; dir_err = 1'b0;
        drive1(16'h00DE, 3'd0);           // mult -2*3
        dir_out = 6'h0F; dir_leds = 16'h0000; dir_err = 1'b0;
        drive0(16'h0D00, 3'd3);           // shift left, serial_in=1, 4 cycles
        dir_out = 6'h00; dir_leds = 16'hFFFF; dir_err = 1'b1;
        drive1(16'h0180, 3'd0);           // opcode 110
        dir_out = 6'h00; dir_leds = 16'h0000; dir_err = 1'b0;
        drive1(16'h1043, 3'd0);           // reduction XOR of 3'b011
        dir_on = 1'b0;
        drain();

        // both requesters contending: grants alternate
        fork
            begin drive0(rand_cmd(), 3'd0); drive0(rand_cmd(), 3'd1); end
            begin drive1(rand_cmd(), 3'd0); drive1(rand_cmd(), 3'd2); end
        join
        drain();

        // response stall on requester 1 while requester 0 keeps asking
        rdy_mode = 2;
        fork
            begin drive0(rand_cmd(), 3'd0); drive0(rand_cmd(), 3'd0); end
            drive1(rand_cmd(), 3'd1);
            begin
                for (int i = 0; i < 200 && !rsp1_valid; i++) @(negedge clk);
                repeat (3) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        // reset while waiting on the ALSU pipeline
        drive0(16'h0293, 3'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        fork
            drive0(rand_cmd(), 3'($urandom_range(0, 7)));
            drive1(rand_cmd(), 3'($urandom_range(0, 7)));
        join
        drain();

        // randomized traffic with random response back-pressure
        rdy_mode = 1;
        fork
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                drive0(rand_cmd(), 3'($urandom_range(0, 7)));
            end
            for (int j = 0; j < 30; j++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                drive1(rand_cmd(), 3'($urandom_range(0, 7)));
            end
        join
        drain();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
